tdc_readout: RTL and testbench
==============================

Name: tdc_readout

Overview:
- Consumer end of the TDC merge stage.
- Captures each merged measurement word on the merge stage's one-cycle `done` pulse and buffers it in a small synchronous FIFO.
- Streams each word out as a framed byte sequence over a valid/ready byte interface that feeds the UART transmitter.
- Decouples the bursty TDC measurement rate from the slow host link and reports lost words.

Parameters:
- DATA_W, 24, width of merged word ({Coarse, StartEdge, FallEdge}, 3 x NUM_DECODE).
- DEPTH, 16, FIFO depth in words; power of 2, minimum 2.
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- irst_n  in  1  asynchronous active-low reset.
- done  in  1  one-cycle strobe from merge stage; din is valid in the same cycle.
- din  in  DATA_W  merged measurement word.
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_ready  in  1  transmitter accepts the byte this cycle.
- fifo_level  out  $clog2(DEPTH)+1  words stored.
- overflow  out  1  sticky flag: at least one word was dropped.
- drop_cnt  out  8  saturating count of dropped words.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset (irst_n low, async): tx_valid=0, tx_data=0, fifo_level=0, overflow=0, drop_cnt=0, busy=0, FSM=IDLE, FIFO pointers 0.
- Push:
  - done=1 writes din at that edge if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped: overflow set, drop_cnt incremented, saturating at 255.
- Simultaneous push+pop: level unchanged.
- clr_ovf and a drop in the same cycle: clear wins.
- Byte count NB = ceil(DATA_W/8). The word is zero-extended to NB*8 bits and sent MSB byte first.
- Frame = SYNC_BYTE, then NB data bytes.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the shift register; tx_data=SYNC_BYTE, tx_valid=1; go to HDR.
  - HDR: on tx_valid&tx_ready, load the first data byte; go to DATA with byte index = NB-1.
  - DATA: on each handshake, load the next byte and decrement the index.
    - On the handshake of the last byte, if the FIFO is non-empty, pop and present SYNC_BYTE directly (back-to-back frames, no idle cycle) and go to HDR.
    - Otherwise drop tx_valid and go to IDLE.
- Handshake rules:
  - tx_data and tx_valid are registered.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable and tx_valid stays high.
  - tx_valid never deasserts without a handshake.
  - tx_ready while tx_valid=0 is ignored.
- Latency: done at edge k with the FIFO empty and FSM IDLE → tx_valid=1 with SYNC_BYTE after edge k+1 (FIFO non-empty is seen at k+1).
- Throughput: with tx_ready held high, one byte per cycle; frame occupies NB+1 cycles.
- fifo_level is registered and reflects pushes and pops of the previous edge. The word held in the shift register is not counted.
- busy = (FSM != IDLE) | (fifo_level != 0).
- Pointer wrap: pointers are $clog2(DEPTH)+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal.
- Reset mid-frame: frame abandoned, no partial resume; buffered words lost.
- done while irst_n low: ignored.

Optional Feature:
- READOUT_TIMESTAMP_EN defined:
  - A 16-bit free-running cycle counter (reset 0, wraps 16'hFFFF→0) is sampled together with din on a successful push and stored alongside it. FIFO entry width becomes DATA_W+16.
  - Frame = SYNC_BYTE, NB data bytes, then timestamp MSB, then LSB. An FSM state TS covers these 2 bytes.
  - Dropped words do not consume a timestamp.
- Undefined: no counter, no TS state; frame exactly as above.

Decomposition:
- Shared package/defines:
  - SYNC_BYTE default value.
  - FSM state encoding (IDLE, HDR, DATA, TS).
  - NB computation macro/function.
  - Timestamp width constant (16).
- One sub-module: tdc_sync_fifo (parameterised width/depth, push/pop/full/empty/level). It does not implement the overflow policy; tdc_readout owns that.

Test Plan:
- Single word: reset, done with din=24'h123456, tx_ready=1 → bytes A5,12,34,56 on consecutive cycles, tx_valid first high 1 cycle after done; then tx_valid=0, busy=0.
- Backpressure: same word, tx_ready toggled 0/1 every cycle → each byte held stable while not accepted, sequence A5,12,34,56 exactly once.
- Back-to-back: two done pulses 1 cycle apart (24'hABCDEF, 24'h000001), tx_ready=1 → 8 contiguous valid cycles: A5,AB,CD,EF,A5,00,00,01.
- Overflow: tx_ready=0, 20 done pulses with DEPTH=16 → fifo_level=16; the word in the shift register is also held, so overflow=1, drop_cnt=3; clr_ovf → both 0, stored data still drains correctly.
- Full+pop same cycle: FIFO full, done coincident with a pop → word accepted, fifo_level stays 16, drop_cnt unchanged.
- Reset mid-frame: irst_n low after byte 2 of a frame → tx_valid=0 immediately, fifo_level=0. After release, a new done with 24'h00FF00 gives A5,00,FF,00. With READOUT_TIMESTAMP_EN, done at counter value 16'h0005 appends 00,05.

Source files
------------

// File: rtl/tdc_readout_pkg.sv
// Shared definitions for the TDC readout path: frame header default, FSM
// state encoding, byte-count helper and timestamp width.
// Optional feature macro: READOUT_TIMESTAMP_EN (see tdc_readout.sv).
package tdc_readout_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned TS_W          = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_TS   = 2'd3
  } state_e;

  // Number of bytes needed to carry a w-bit word.
  function automatic int unsigned nb_bytes(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Ports:
//   clk, irst_n        clock, async active-low reset
//   push, wdata        write request/data (caller guarantees no push when full
//                      unless a pop happens in the same cycle)
//   pop                read request (caller guarantees not empty)
//   rdata_c            head entry (combinational from storage)
//   full_c, empty_c    status decoded from the pointers
//   level              registered number of stored entries
module tdc_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     irst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + PTR_W'(push) - PTR_W'(pop);
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  // Same low bits with differing wrap bits means the writer lapped the reader
  always_comb begin
    rdata_c = mem_q[rd_ptr_q[AW-1:0]];
    full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_c = (wr_ptr_q == rd_ptr_q);
  end

  assign level = level_q;

endmodule

// File: rtl/tdc_readout.sv
// TDC readout: buffers merged measurement words captured on `done` and
// streams each as a byte frame {SYNC_BYTE, data MSB..LSB} over valid/ready.
// Optional macro READOUT_TIMESTAMP_EN appends a 16-bit cycle timestamp
// (MSB, LSB) sampled when the word was pushed.
// Ports:
//   clk, irst_n          clock, async active-low reset
//   done, din            one-cycle capture strobe and merged word
//   clr_ovf              synchronous clear of overflow / drop_cnt
//   tx_data, tx_valid    registered byte stream to the UART transmitter
//   tx_ready             transmitter accepts the byte this cycle
//   fifo_level           words stored (excludes the word being framed)
//   overflow, drop_cnt   sticky drop flag and saturating drop count
//   busy                 frame in progress or FIFO non-empty
module tdc_readout
  import tdc_readout_pkg::*;
#(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                    clk,
  input  logic                    irst_n,
  input  logic                    done,
  input  logic [DATA_W-1:0]       din,
  input  logic                    clr_ovf,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  output logic [7:0]              drop_cnt,
  output logic                    busy
);

  localparam int unsigned NB    = nb_bytes(DATA_W);
  localparam int unsigned PAY_W = NB * 8;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = (NB > 2) ? $clog2(NB) : 1;
`ifdef READOUT_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = DATA_W + TS_W;
  localparam int unsigned SHIFT_W = PAY_W + TS_W;
`else
  localparam int unsigned ENTRY_W = DATA_W;
  localparam int unsigned SHIFT_W = PAY_W;
`endif

  state_e               state_q, state_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic                 busy_q, busy_d;

  logic                 hs_c, start_c, frame_done_c, pop_c, push_c, drop_c;
  logic [ENTRY_W-1:0]   fifo_wdata_c, fifo_rdata_c;
  logic [SHIFT_W-1:0]   payload_c;
  logic                 fifo_full_c, fifo_empty_c;
  logic [LVL_W-1:0]     level_nxt_c;

`ifdef READOUT_TIMESTAMP_EN
  logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;

  // Free-running cycle counter, wraps naturally
  always_comb ts_cnt_d = ts_cnt_q + TS_W'(1);

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) ts_cnt_q <= '0;
    else         ts_cnt_q <= ts_cnt_d;
  end

  always_comb begin
    fifo_wdata_c = {din, ts_cnt_q};
    payload_c    = {PAY_W'(fifo_rdata_c[ENTRY_W-1 -: DATA_W]), fifo_rdata_c[TS_W-1:0]};
  end
`else
  always_comb begin
    fifo_wdata_c = din;
    payload_c    = PAY_W'(fifo_rdata_c);
  end
`endif

  tdc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .irst_n  (irst_n),
    .push    (push_c),
    .wdata   (fifo_wdata_c),
    .pop     (pop_c),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .level   (fifo_level)
  );

  // Framing FSM: next state, byte selection and pop request
  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    start_c      = 1'b0;
    frame_done_c = 1'b0;
    hs_c         = tx_valid_q & tx_ready;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) start_c = 1'b1;
      end
      ST_HDR: begin
        if (hs_c) begin
          tx_data_d = shift_q[SHIFT_W-1 -: 8];
          shift_d   = shift_q << 8;
          idx_d     = IDX_W'(NB - 1);
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hs_c) begin
          if (idx_q != '0) begin
            tx_data_d = shift_q[SHIFT_W-1 -: 8];
            shift_d   = shift_q << 8;
            idx_d     = idx_q - IDX_W'(1);
          end else begin
`ifdef READOUT_TIMESTAMP_EN
            tx_data_d = shift_q[SHIFT_W-1 -: 8];
            shift_d   = shift_q << 8;
            idx_d     = IDX_W'(1);
            state_d   = ST_TS;
`else
            frame_done_c = 1'b1;
`endif
          end
        end
      end
`ifdef READOUT_TIMESTAMP_EN
      ST_TS: begin
        if (hs_c) begin
          if (idx_q != '0) begin
            tx_data_d = shift_q[SHIFT_W-1 -: 8];
            shift_d   = shift_q << 8;
            idx_d     = idx_q - IDX_W'(1);
          end else begin
            frame_done_c = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    // Last byte accepted: chain the next frame without an idle cycle if possible
    if (frame_done_c) begin
      if (!fifo_empty_c) begin
        start_c = 1'b1;
      end else begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    end

    if (start_c) begin
      shift_d    = payload_c;
      tx_data_d  = SYNC_BYTE;
      tx_valid_d = 1'b1;
      state_d    = ST_HDR;
    end
  end

  // Push/drop policy and status registers; a pop frees the slot being written
  always_comb begin
    pop_c       = start_c;
    push_c      = done & (~fifo_full_c | pop_c);
    drop_c      = done & ~push_c;
    level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
    busy_d = (state_d != ST_IDLE) | (level_nxt_c != '0);
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state_q    <= ST_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      shift_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Self-checking bench for tdc_readout: directed scenarios plus a random
// phase, all compared every cycle against a queue-based reference model.
module tb_tdc_readout;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NB     = (DATA_W + 7) / 8;
  localparam logic [7:0]  SYNC   = 8'hA5;
`ifdef READOUT_TIMESTAMP_EN
  localparam int unsigned FL = NB + 3;
`else
  localparam int unsigned FL = NB + 1;
`endif

  logic                   clk;
  logic                   irst_n;
  logic                   done;
  logic [DATA_W-1:0]      din;
  logic                   clr_ovf;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic [7:0]             drop_cnt;
  logic                   busy;

  tdc_readout dut (
    .clk        (clk),
    .irst_n     (irst_n),
    .done       (done),
    .din        (din),
    .clr_ovf    (clr_ovf),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: stored words, their timestamps, bytes of the current frame
  logic [DATA_W-1:0] mq[$];
  logic [15:0]       mts[$];
  logic [7:0]        mfr[$];
  int                m_drop;
  bit                m_ovf;
  logic [15:0]       m_ts;
  logic [7:0]        got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    mts.delete();
    mfr.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
    m_ts   = 16'd0;
  endfunction

  // A new frame starts when idle, or right as the final byte is accepted
  function automatic bit model_pops(input bit rdy);
    return (mq.size() != 0) && ((mfr.size() == 0) || (rdy && mfr.size() == 1));
  endfunction

  function automatic void model_edge(input bit d, input logic [DATA_W-1:0] w,
                                     input bit rdy, input bit c);
    bit              pop;
    bit              push;
    logic [NB*8-1:0] ext;
`ifdef READOUT_TIMESTAMP_EN
    logic [15:0]     t;
`endif
    pop  = model_pops(rdy);
    push = d && ((mq.size() < int'(DEPTH)) || pop);
    if (mfr.size() != 0 && rdy) void'(mfr.pop_front());
    if (pop) begin
      ext = (NB*8)'(mq.pop_front());
      mfr.push_back(SYNC);
      for (int b = int'(NB) - 1; b >= 0; b--) mfr.push_back(ext[b*8 +: 8]);
`ifdef READOUT_TIMESTAMP_EN
      t = mts.pop_front();
      mfr.push_back(t[15:8]);
      mfr.push_back(t[7:0]);
`else
      void'(mts.pop_front());
`endif
    end
    if (push) begin
      mq.push_back(w);
      mts.push_back(m_ts);
    end
    if (c) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (d && !push) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
    m_ts = m_ts + 16'd1;
  endfunction

  task automatic compare_all();
    check("tx_valid", 32'(tx_valid), 32'(mfr.size() != 0));
    if (mfr.size() != 0) check("tx_data", 32'(tx_data), 32'(mfr[0]));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("busy", 32'(busy), 32'((mfr.size() != 0) || (mq.size() != 0)));
  endtask

  // One clock: drive inputs, log accepted byte, advance model, compare
  task automatic step(input bit d, input logic [DATA_W-1:0] w, input bit rdy, input bit c);
    done     = d;
    din      = w;
    tx_ready = rdy;
    clr_ovf  = c;
    if (tx_valid && rdy) got.push_back(tx_data);
    @(posedge clk);
    model_edge(d, w, rdy, c);
    #1;
    compare_all();
    done    = 1'b0;
    clr_ovf = 1'b0;
  endtask

  // Compare k-th header/data byte across frames laid out FL bytes apart
  task automatic check_frames(input string tag, input logic [7:0] exp[], input int nframes);
    check({tag, "_len"}, 32'(got.size()), 32'(nframes * int'(FL)));
    for (int k = 0; k < exp.size(); k++) begin
      int gi;
      gi = (k / int'(NB + 1)) * int'(FL) + (k % int'(NB + 1));
      if (gi < got.size()) check($sformatf("%s_b%0d", tag, k), 32'(got[gi]), 32'(exp[k]));
      else check($sformatf("%s_b%0d_missing", tag, k), 32'(gi), 32'(got.size()));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] e1[];
    logic [7:0] e3[];
    logic [7:0] e6[];
    int         first_v;
    int         last_v;
    int         cyc;
    bit         hit;

    irst_n   = 1'b0;
    done     = 1'b1;
    din      = 24'h777777;
    clr_ovf  = 1'b0;
    tx_ready = 1'b1;
    model_reset();

    // Reset values; done during reset must be ignored
    #12;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    done = 1'b0;
    #8;
    irst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);

    // Single word
    got.delete();
    step(1'b1, 24'h123456, 1'b1, 1'b0);
    check("t1_no_valid_yet", 32'(tx_valid), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t1_first_valid", 32'(tx_valid), 32'd1);
    check("t1_first_byte", 32'(tx_data), 32'hA5);
    drain(int'(FL) + 2);
    e1 = new[4];
    e1[0] = 8'hA5; e1[1] = 8'h12; e1[2] = 8'h34; e1[3] = 8'h56;
    check_frames("t1", e1, 1);
    check("t1_idle_valid", 32'(tx_valid), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Backpressure: ready toggles every cycle
    got.delete();
    step(1'b1, 24'h123456, 1'b0, 1'b0);
    for (int i = 0; i < 2 * int'(FL) + 6; i++) step(1'b0, '0, 1'(i % 2), 1'b0);
    check_frames("t2", e1, 1);
    check("t2_idle_busy", 32'(busy), 32'd0);

    // Back-to-back frames, no idle gap
    got.delete();
    first_v = -1;
    last_v  = -1;
    cyc     = 0;
    for (int i = 0; i < 2 * int'(FL) + 5; i++) begin
      if (i == 0) step(1'b1, 24'hABCDEF, 1'b1, 1'b0);
      else if (i == 1) step(1'b1, 24'h000001, 1'b1, 1'b0);
      else step(1'b0, '0, 1'b1, 1'b0);
      if (tx_valid) begin
        cyc++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    e3 = new[8];
    e3[0] = 8'hA5; e3[1] = 8'hAB; e3[2] = 8'hCD; e3[3] = 8'hEF;
    e3[4] = 8'hA5; e3[5] = 8'h00; e3[6] = 8'h00; e3[7] = 8'h01;
    check_frames("t3", e3, 2);
    check("t3_valid_cycles", 32'(cyc), 32'(2 * FL));
    check("t3_contiguous", 32'(last_v - first_v + 1), 32'(2 * FL));

    // Overflow with the link stalled
    for (int i = 0; i < 20; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    check("t4_level", 32'(fifo_level), 32'(DEPTH));
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_drop_cnt", 32'(drop_cnt), 32'd3);
    step(1'b1, 24'h555555, 1'b0, 1'b1);
    check("t4_clr_overflow", 32'(overflow), 32'd0);
    check("t4_clr_drop_cnt", 32'(drop_cnt), 32'd0);

    // Full FIFO: push coincident with a pop is accepted
    hit = 1'b0;
    for (int i = 0; i < 3 * int'(FL); i++) begin
      if (!hit && model_pops(1'b1)) begin
        step(1'b1, 24'hC0FFEE, 1'b1, 1'b0);
        check("t5_level", 32'(fifo_level), 32'(DEPTH));
        check("t5_drop_cnt", 32'(drop_cnt), 32'd0);
        hit = 1'b1;
      end else begin
        step(1'b0, '0, 1'b1, 1'b0);
      end
    end
    check("t5_hit", 32'(hit), 32'd1);
    drain((int'(DEPTH) + 2) * int'(FL) + 4);
    check("t5_drained_busy", 32'(busy), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
    check("t6_drop_sat", 32'(drop_cnt), 32'd255);
    step(1'b0, '0, 1'b0, 1'b1);
    drain((int'(DEPTH) + 2) * int'(FL) + 4);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      bit d, r, c;
      d = ($urandom_range(0, 3) != 0) && (i % 400 < 300);
      r = (i % 500 < 250) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      step(d, DATA_W'($urandom), r, c);
    end
    drain((int'(DEPTH) + 2) * int'(FL) + 4);

    // Reset in the middle of a frame with words buffered
    step(1'b1, 24'h112233, 1'b1, 1'b0);
    step(1'b1, 24'h445566, 1'b1, 1'b0);
    step(1'b1, 24'h778899, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    irst_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(tx_valid), 32'd0);
    check("t7_rst_level", 32'(fifo_level), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    irst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    got.delete();
    step(1'b1, 24'h00FF00, 1'b1, 1'b0);
    drain(int'(FL) + 3);
    e6 = new[4];
    e6[0] = 8'hA5; e6[1] = 8'h00; e6[2] = 8'hFF; e6[3] = 8'h00;
    check_frames("t7", e6, 1);
`ifdef READOUT_TIMESTAMP_EN
    if (got.size() >= 6) begin
      check("t7_ts_msb", 32'(got[4]), 32'h00);
      check("t7_ts_lsb", 32'(got[5]), 32'h05);
    end else begin
      check("t7_ts_missing", 32'(got.size()), 32'd6);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
